// File: rtl/rv32i_types.sv
// rv32i_types: shared state encodings for the pipeline sequencing controller
package rv32i_types;
  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_HOLD, F_DROP} fetch_state_t;
  typedef enum logic {D_IDLE, D_WAIT} dmem_state_t;
endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// hazard_unit: load-use detection and qualification of EX redirects against back-end stalls
module hazard_unit (
  input  logic       id_valid,
  input  logic [4:0] id_rs1_s,
  input  logic [4:0] id_rs2_s,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd_s,
  input  logic       ex_redirect,
  input  logic       back_stall,
  output logic       load_use,
  output logic       redir
);
  assign load_use = id_valid && ex_is_load && ex_rd_s != 5'd0 && (ex_rd_s == id_rs1_s || ex_rd_s == id_rs2_s);
  assign redir = ex_redirect && !back_stall;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline sequencing, fetch/data request tracking and perf counters
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_resp,
  input  logic             mem_op,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd_s,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_s,
  input  logic [4:0]       id_rs2_s,
  input  logic             ex_redirect,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_bubble,
  output logic             id_ex_bubble,
  output logic             ibuf_we,
  output logic             ibuf_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  fetch_state_t     f_q, f_d;
  dmem_state_t      d_q, d_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             back_stall, load_use, redir, adv;

  assign back_stall = mem_op && !(d_q == D_WAIT && dmem_resp);
  assign adv = !back_stall && !load_use;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  hazard_unit u_hazard (
    .id_valid    (id_valid),
    .id_rs1_s    (id_rs1_s),
    .id_rs2_s    (id_rs2_s),
    .ex_is_load  (ex_is_load),
    .ex_rd_s     (ex_rd_s),
    .ex_redirect (ex_redirect),
    .back_stall  (back_stall),
    .load_use    (load_use),
    .redir       (redir)
  );

  always_comb begin
    f_d = f_q;
    d_d = d_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    pc_we = 1'b0;
    if_id_we = 1'b0;
    if_id_bubble = 1'b0;
    ibuf_we = 1'b0;
    ibuf_sel = 1'b0;
    id_ex_we = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_we = 1'b0;
    mem_wb_we = 1'b0;
    stall_cnt_d = (back_stall || load_use) && !(&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = redir && !(&flush_cnt_q) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    if (!rst) begin
      ex_mem_we = !back_stall;
      mem_wb_we = !back_stall;
      id_ex_we = !back_stall;
      id_ex_bubble = !back_stall && (load_use || redir || !id_valid);
      dmem_req = d_q == D_IDLE && mem_op;
      d_d = d_q == D_IDLE ? (mem_op ? D_WAIT : D_IDLE) : (dmem_resp ? D_IDLE : D_WAIT);
      case (f_q)
        F_IDLE: begin
          // a redirect with nothing in flight only moves the PC; fetch resumes from the new PC next cycle
          if (redir) begin
            pc_we = 1'b1;
            if_id_we = 1'b1;
            if_id_bubble = 1'b1;
          end else if (!back_stall) begin
            imem_req = 1'b1;
            f_d = F_WAIT;
          end
        end
        F_WAIT: begin
          if (redir) begin
            pc_we = 1'b1;
            if_id_we = 1'b1;
            if_id_bubble = 1'b1;
            f_d = imem_resp ? F_IDLE : F_DROP;
          end else if (imem_resp && adv) begin
            if_id_we = 1'b1;
            pc_we = 1'b1;
            imem_req = 1'b1;
          end else if (imem_resp) begin
            ibuf_we = 1'b1;
            f_d = F_HOLD;
          end else if (adv) begin
            if_id_we = 1'b1;
            if_id_bubble = 1'b1;
          end
        end
        F_HOLD: begin
          if (redir) begin
            pc_we = 1'b1;
            if_id_we = 1'b1;
            if_id_bubble = 1'b1;
            f_d = F_IDLE;
          end else if (adv) begin
            ibuf_sel = 1'b1;
            if_id_we = 1'b1;
            pc_we = 1'b1;
            imem_req = 1'b1;
            f_d = F_WAIT;
          end
        end
        default: begin
          pc_we = redir;
          f_d = imem_resp ? F_IDLE : F_DROP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q <= F_IDLE;
      d_q <= D_IDLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      f_q <= f_d;
      d_q <= d_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios plus randomized traffic checked against a flag-based reference model
module tb_pipeline_ctrl;
  localparam int CW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_resp, dmem_resp, mem_op, ex_is_load, id_valid, ex_redirect;
  logic [4:0] ex_rd_s, id_rs1_s, id_rs2_s;
  logic imem_req, dmem_req, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_bubble, id_ex_bubble, ibuf_we, ibuf_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [10:0] act;
  int total = 0, bad = 0, n_req;
  logic m_live = 0, m_dead = 0, m_buf = 0, m_dbusy = 0;
  int m_stall = 0, m_flush = 0;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp), .mem_op(mem_op),
    .ex_is_load(ex_is_load), .ex_rd_s(ex_rd_s), .id_valid(id_valid), .id_rs1_s(id_rs1_s),
    .id_rs2_s(id_rs2_s), .ex_redirect(ex_redirect), .imem_req(imem_req), .dmem_req(dmem_req),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble),
    .ibuf_we(ibuf_we), .ibuf_sel(ibuf_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;
  assign act = {imem_req, dmem_req, pc_we, if_id_we, if_id_bubble, ibuf_we, ibuf_sel,
                id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  // Fetch is tracked as "in flight / killed / buffered" flags, data as "busy"
  always @(negedge clk) begin
    logic bs, lu, rd, adv, ireq, dreq, pc, ifid, ifb, ibw, ibs;
    logic [10:0] exp_v;
    if (rst) begin
      m_live = 0; m_dead = 0; m_buf = 0; m_dbusy = 0; m_stall = 0; m_flush = 0;
    end
    bs = mem_op && !(m_dbusy && dmem_resp);
    lu = id_valid && ex_is_load && ex_rd_s != 0 && (ex_rd_s == id_rs1_s || ex_rd_s == id_rs2_s);
    rd = ex_redirect && !bs;
    adv = !bs && !lu;
    dreq = !m_dbusy && mem_op;
    {ireq, pc, ifid, ifb, ibw, ibs} = '0;
    if (m_buf) begin
      if (rd) begin pc = 1; ifid = 1; ifb = 1; m_buf = 0; end
      else if (adv) begin ibs = 1; ifid = 1; pc = 1; ireq = 1; m_buf = 0; m_live = 1; end
    end else if (m_live && m_dead) begin
      pc = rd;
      if (imem_resp) begin m_live = 0; m_dead = 0; end
    end else if (m_live) begin
      if (rd) begin
        pc = 1; ifid = 1; ifb = 1;
        if (imem_resp) m_live = 0; else m_dead = 1;
      end else if (imem_resp && adv) begin ifid = 1; pc = 1; ireq = 1; end
      else if (imem_resp) begin ibw = 1; m_live = 0; m_buf = 1; end
      else if (adv) begin ifid = 1; ifb = 1; end
    end else if (rd) begin pc = 1; ifid = 1; ifb = 1; end
    else if (!bs) begin ireq = 1; m_live = 1; end
    exp_v = rst ? 11'd0 : {ireq, dreq, pc, ifid, ifb, ibw, ibs, !bs, !bs && (lu || rd || !id_valid), !bs, !bs};
    chk("model_outs", 32'(act), 32'(exp_v));
    chk("model_stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("model_flush_cnt", 32'(flush_cnt), 32'(m_flush));
    if (dreq) m_dbusy = 1; else if (m_dbusy && dmem_resp) m_dbusy = 0;
    if (bs || lu) m_stall = m_stall < 15 ? m_stall + 1 : 15;
    if (rd) m_flush = m_flush < 15 ? m_flush + 1 : 15;
    if (rst) begin
      m_live = 0; m_dead = 0; m_buf = 0; m_dbusy = 0; m_stall = 0; m_flush = 0;
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); #1; endtask
  task automatic clr();
    {imem_resp, dmem_resp, mem_op, ex_is_load, id_valid, ex_redirect} = '0;
    ex_rd_s = 0; id_rs1_s = 0; id_rs2_s = 0;
  endtask
  task automatic reset_seq();
    tick(); rst = 1; clr(); tick(); tick(); rst = 0;
  endtask

  initial begin
    clr();
    tick(); mid();
    chk("rst_outs", 32'(act), 0);
    chk("rst_cnts", {stall_cnt, flush_cnt}, 0);
    tick(); rst = 0; imem_resp = 1;
    mid();
    chk("stream_c1_imem_req", imem_req, 1);
    chk("stream_c1_pc_we", pc_we, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); mid();
      chk("stream_req_ifid_pc", {imem_req, if_id_we, pc_we}, 3'b111);
    end
    chk("stream_stall_cnt", stall_cnt, 0);
    tick(); ex_is_load = 1; ex_rd_s = 5; id_rs1_s = 5; id_valid = 1;
    mid();
    chk("lu_ifid_pc_bub_ibuf", {if_id_we, pc_we, id_ex_bubble, ibuf_we}, 4'b0011);
    tick(); ex_is_load = 0;
    mid();
    chk("lu_release_ibuf_sel", {ibuf_sel, if_id_we, imem_req}, 3'b111);
    chk("lu_stall_cnt", stall_cnt, 1);
    tick(); ex_is_load = 1; ex_rd_s = 0; id_rs1_s = 0;
    mid();
    chk("lu_rd0_no_stall", {if_id_we, pc_we, id_ex_bubble}, 3'b110);
    tick(); mid();
    chk("lu_rd0_stall_cnt", stall_cnt, 1);

    reset_seq(); mem_op = 1; n_req = 0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) dmem_resp = 1;
      mid();
      n_req += int'(dmem_req);
      chk("mem_back_we", {ex_mem_we, mem_wb_we}, c < 4 ? 2'b00 : 2'b11);
      tick();
    end
    mem_op = 0; dmem_resp = 0;
    mid();
    chk("mem_req_pulses", n_req, 1);
    chk("mem_stall_cnt", stall_cnt, 3);

    reset_seq();
    mid(); chk("redir_c1_imem_req", imem_req, 1);
    tick(); ex_redirect = 1;
    mid(); chk("redir_ctrl", {pc_we, if_id_we, if_id_bubble, id_ex_bubble}, 4'b1111);
    tick(); ex_redirect = 0;
    mid(); chk("drop_wait_ifid", if_id_we, 0);
    tick(); imem_resp = 1;
    mid(); chk("drop_resp_ignored", {if_id_we, imem_req, ibuf_we, pc_we}, 0);
    tick(); imem_resp = 0;
    mid(); chk("drop_then_req", imem_req, 1);
    chk("redir_flush_cnt", flush_cnt, 1);

    reset_seq();
    tick(); ex_redirect = 1;
    tick(); ex_redirect = 0; mem_op = 1;
    mid(); chk("mid_dmem_req", dmem_req, 1);
    tick(); rst = 1; mem_op = 0;
    mid(); chk("mid_rst_outs", 32'(act), 0);
    tick(); rst = 0; dmem_resp = 1; imem_resp = 1;
    mid();
    chk("late_resp_no_enables", {dmem_req, pc_we, if_id_we, ibuf_we, ibuf_sel}, 0);
    chk("late_resp_imem_req", imem_req, 1);
    chk("late_resp_cnts", {stall_cnt, flush_cnt}, 0);

    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = $urandom_range(0, 149) == 0;
      mem_op = $urandom_range(0, 3) == 0;
      dmem_resp = $urandom_range(0, 1) == 1;
      imem_resp = $urandom_range(0, 1) == 1;
      ex_is_load = $urandom_range(0, 1) == 1;
      id_valid = $urandom_range(0, 3) != 0;
      ex_redirect = $urandom_range(0, 5) == 0;
      ex_rd_s = 5'($urandom_range(0, 3));
      id_rs1_s = 5'($urandom_range(0, 3));
      id_rs2_s = 5'($urandom_range(0, 3));
    end
    tick(); mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
